// File: rtl/comp.sv
// Registered two-operand magnitude comparator with max/min selection, one cycle latency.
// Optional COMP_SIGNED_EN adds an is_signed port selecting two's-complement ordering.
module comp #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   input  logic         in_valid,
`ifdef COMP_SIGNED_EN
   input  logic         is_signed,
`endif
   output logic         gt,
   output logic         eq,
   output logic         lt,
   output logic [N-1:0] max_out,
   output logic [N-1:0] min_out,
   output logic         out_valid
);

   // Extending by one bit lets a single signed compare serve both orderings:
   // the extension bit is the operand MSB for signed mode and zero otherwise.
   function automatic logic less_than(input logic [N-1:0] a,
                                      input logic [N-1:0] b,
                                      input logic         sgn);
      logic signed [N:0] sa;
      logic signed [N:0] sb;
      sa = {sgn & a[N-1], a};
      sb = {sgn & b[N-1], b};
      return sa < sb;
   endfunction

   logic         sgn_p0;
   logic         gt_p0;
   logic         eq_p0;
   logic         lt_p0;
   logic [N-1:0] max_p0;
   logic [N-1:0] min_p0;

   logic         gt_p1;
   logic         eq_p1;
   logic         lt_p1;
   logic [N-1:0] max_p1;
   logic [N-1:0] min_p1;
   logic         vld_p1;

`ifdef COMP_SIGNED_EN
   assign sgn_p0 = is_signed;
`else
   assign sgn_p0 = 1'b0;
`endif

   // Stage p0: combinational compare of the operands presented this cycle
   always_comb begin
      lt_p0  = less_than(in0, in1, sgn_p0);
      gt_p0  = less_than(in1, in0, sgn_p0);
      eq_p0  = (in0 == in1);
      max_p0 = lt_p0 ? in1 : in0;
      min_p0 = lt_p0 ? in0 : in1;
   end

   // Stage p1: result registers; data holds when no valid operands arrive
   always_ff @(posedge clk) begin
      if (rst) begin
         gt_p1  <= 1'b0;
         eq_p1  <= 1'b0;
         lt_p1  <= 1'b0;
         max_p1 <= '0;
         min_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            gt_p1  <= gt_p0;
            eq_p1  <= eq_p0;
            lt_p1  <= lt_p0;
            max_p1 <= max_p0;
            min_p1 <= min_p0;
         end
      end
   end

   assign gt        = gt_p1;
   assign eq        = eq_p1;
   assign lt        = lt_p1;
   assign max_out   = max_p1;
   assign min_out   = min_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_comp.sv
// Bench for comp: table-driven vectors, reset and hold sequences, random sweep,
// expected results queued at drive time and popped one cycle later.
module tb_comp;
   localparam int N = 8;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         v;
      logic         s;
      logic         g;
      logic         e;
      logic         l;
      logic [N-1:0] mx;
      logic [N-1:0] mn;
   } vec_t;

   typedef struct {
      logic         g;
      logic         e;
      logic         l;
      logic [N-1:0] mx;
      logic [N-1:0] mn;
      logic         ov;
      string        nm;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] in0;
   logic [N-1:0] in1;
   logic         in_valid;
   logic         gt, eq, lt, out_valid;
   logic [N-1:0] max_out, min_out;
`ifdef COMP_SIGNED_EN
   logic         is_signed;
`endif

   int   applied = 0;
   int   miscompares = 0;
   exp_t sb_q[$];
   exp_t last;

   always #5 clk = ~clk;

   comp #(.N(N)) dut (
      .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in_valid(in_valid),
`ifdef COMP_SIGNED_EN
      .is_signed(is_signed),
`endif
      .gt(gt), .eq(eq), .lt(lt), .max_out(max_out), .min_out(min_out),
      .out_valid(out_valid)
   );

   task automatic check_one();
      exp_t x;
      if (sb_q.size() == 0) begin
         $display("FAIL scoreboard-empty: no expected entry queued");
         miscompares++;
         return;
      end
      x = sb_q.pop_front();
      applied++;
      if ({gt, eq, lt, max_out, min_out, out_valid} !== {x.g, x.e, x.l, x.mx, x.mn, x.ov}) begin
         miscompares++;
         $display("FAIL %s: got gt=%b eq=%b lt=%b max=%h min=%h ov=%b, expected gt=%b eq=%b lt=%b max=%h min=%h ov=%b",
                  x.nm, gt, eq, lt, max_out, min_out, out_valid,
                  x.g, x.e, x.l, x.mx, x.mn, x.ov);
      end
   endtask

   // Drive one cycle of stimulus, queue what should appear after the edge, then check it.
   task automatic apply(input vec_t t, input logic r, input string nm);
      exp_t x;
      @(negedge clk);
      rst      = r;
      in0      = t.a;
      in1      = t.b;
      in_valid = t.v;
`ifdef COMP_SIGNED_EN
      is_signed = t.s;
`endif
      if (r) begin
         x = '{1'b0, 1'b0, 1'b0, '0, '0, 1'b0, nm};
      end else if (t.v) begin
         x = '{t.g, t.e, t.l, t.mx, t.mn, 1'b1, nm};
      end else begin
         x = last;
         x.ov = 1'b0;
         x.nm = nm;
      end
      last = x;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      check_one();
   endtask

   // Independent reference: map operands to integers and compare numerically.
   function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
      vec_t   t;
      longint ia, ib;
      ia = longint'(a);
      ib = longint'(b);
      if (s && a[N-1]) ia = ia - (longint'(1) << N);
      if (s && b[N-1]) ib = ib - (longint'(1) << N);
      t.a = a; t.b = b; t.v = 1'b1; t.s = s;
      t.g = (ia > ib);
      t.e = (ia == ib);
      t.l = (ia < ib);
      t.mx = (ia < ib) ? b : a;
      t.mn = (ia < ib) ? a : b;
      return t;
   endfunction

   vec_t tbl[10];
   vec_t idle;

   initial begin
      //        a      b      v     s     g     e     l     mx     mn
      tbl[0] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00};
      tbl[1] = '{8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[3] = '{8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[4] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00};
      tbl[5] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00};
      tbl[6] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h7F};
      tbl[7] = '{8'h80, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h01};
      tbl[8] = '{8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 8'h3C};
      tbl[9] = '{8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      idle   = '{8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

      rst = 1'b1; in0 = '0; in1 = '0; in_valid = 1'b0;
`ifdef COMP_SIGNED_EN
      is_signed = 1'b0;
`endif
      last = '{1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "init"};

      apply(idle, 1'b1, "reset_state");
      apply(idle, 1'b1, "reset_state_2");

      for (int i = 0; i < 10; i++) apply(tbl[i], 1'b0, $sformatf("table_%0d", i));

      // Reset with live results and a valid operand pair in the same cycle.
      apply(model(8'hF0, 8'h0F, 1'b0), 1'b0, "pre_reset_nonzero");
      apply(model(8'h22, 8'h11, 1'b0), 1'b1, "reset_overrides_valid");
      apply(idle, 1'b0, "post_reset_idle");
      apply(idle, 1'b0, "post_reset_idle_2");
      apply(model(8'h09, 8'h09, 1'b0), 1'b0, "post_reset_first");

      // Back-to-back stream followed by a bubble and a hold.
      apply(model(8'hFF, 8'h00, 1'b0), 1'b0, "b2b_gt");
      apply(model(8'h00, 8'hFF, 1'b0), 1'b0, "b2b_lt");
      apply(model(8'h7F, 8'h7F, 1'b0), 1'b0, "b2b_eq");
      apply(idle, 1'b0, "b2b_hold");

`ifdef COMP_SIGNED_EN
      apply(model(8'h80, 8'h01, 1'b1), 1'b0, "signed_80_01");
      apply(model(8'h80, 8'h01, 1'b0), 1'b0, "unsigned_80_01");
      apply(model(8'hFF, 8'h01, 1'b1), 1'b0, "signed_ff_01");
      apply(model(8'h7F, 8'h80, 1'b1), 1'b0, "signed_7f_80");
`endif

      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] ra, rb;
         logic         rs;
         vec_t         rv;
         ra = N'($urandom_range(0, 255));
         rb = (i % 5 == 0) ? ra : N'($urandom_range(0, 255));
`ifdef COMP_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         if (i % 7 == 3) rv = idle;
         else            rv = model(ra, rb, rs);
         apply(rv, 1'b0, $sformatf("random_%0d", i));
      end

      if (sb_q.size() != 0) begin
         $display("FAIL scoreboard-drain: %0d entries left, expected 0", sb_q.size());
         miscompares++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
